btn_event_detector: RTL
=======================

Name: btn_event_detector

Overview:
Multi-channel button front end for the simple protocol. It replaces the single-channel IDLE/PRESS/HOLD detector. Per channel, it synchronises a raw pad input, debounces it, runs the IDLE/PRESS/HOLD state machine (encoding my_pkg::state_e), and emits single-cycle event pulses: press, hold, auto-repeat and release. It sits between the board pins and the protocol/command logic; all outputs are synchronous to i_clk.

Parameters:
NUM_CH, 4, number of independent button channels (>=1)
DEB_CYCLES, 16, consecutive stable cycles required to accept a level change (>=1)
HOLD_CYCLES, 1000, cycles in PRESS before promotion to HOLD (>=1)
REPEAT_CYCLES, 200, period of o_repeat pulses while in HOLD (>=1)
ACTIVE_LOW, 0, 1 = raw input is pressed when 0 (inverted after synchroniser)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_btn  in  NUM_CH  raw asynchronous button inputs, bit n = channel n
i_repeat_en  in  NUM_CH  per-channel auto-repeat enable, synchronous
o_press  out  NUM_CH  one-cycle pulse on accepted press
o_hold  out  NUM_CH  one-cycle pulse on PRESS->HOLD
o_repeat  out  NUM_CH  one-cycle pulse every REPEAT_CYCLES in HOLD when enabled
o_release  out  NUM_CH  one-cycle pulse on accepted release from PRESS or HOLD
o_state  out  2*NUM_CH  per-channel state, bits [2n+1:2n], state_e encoding (IDLE=00, PRESS=01, HOLD=10)

Behaviour:
- Reset: asynchronous, active-low; all synchroniser flops, debounced levels and counters go to 0; o_state to IDLE; all pulse outputs to 0. Reset mid-operation aborts silently, with no release pulse. On deassertion, channels start in IDLE even if the button is held; a held button produces o_press after normal debounce latency.
- Synchroniser: 2 flops per channel, followed by optional inversion (ACTIVE_LOW). s = synchronised, normalised level (1 = pressed).
- Debounce: per channel, debounced level d and counter dc of width $clog2(DEB_CYCLES+1).
  - Each edge with s != d: if dc == DEB_CYCLES-1, then d <= s and dc <= 0; else dc++.
  - Any edge with s == d: dc <= 0. A glitch shorter than DEB_CYCLES cycles never changes d.
- FSM per channel, registered, one transition per cycle:
  - IDLE: d==1 -> PRESS, o_press=1 for the first PRESS cycle; hold counter hc <= 0.
  - PRESS: d==0 -> IDLE with o_release pulse. Else, if hc == HOLD_CYCLES-1 -> HOLD with o_hold pulse, repeat counter rc <= 0. Else hc++.
  - HOLD: d==0 -> IDLE with o_release pulse. Else, if rc == REPEAT_CYCLES-1 then rc <= 0 and o_repeat = i_repeat_en[n]; else rc++.
  - Release wins over a simultaneous hold threshold or repeat tick: release pulse only.
  - Unused encoding 11 -> IDLE, no pulses.
- Pulses are registered and coincide with the first cycle of the new o_state value. At most one pulse per channel per cycle.
- Latency: o_press (and o_release) asserts in the cycle after rising edge DEB_CYCLES+3, counting the first edge that samples the new raw level as edge 1.
- HOLD timing: entered exactly HOLD_CYCLES cycles after PRESS entry. First o_repeat comes REPEAT_CYCLES cycles after o_hold.
- i_repeat_en only gates the pulse; rc runs regardless. Enabling mid-HOLD yields a pulse at the next period boundary.
- Channels are fully independent; simultaneous events on different channels all appear in the same cycle.
- Counter widths: $clog2(P+1) of the relevant parameter; no wrap beyond terminal values.

Test Plan:
Common setup: NUM_CH=2, DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, ACTIVE_LOW=0.
1. Reset with i_btn=0 -> all outputs 0 and o_state=0. Raise i_btn[0] and hold it -> o_press[0] is a single pulse in the cycle after edge 7, o_state[1:0]=01, and channel 1 stays untouched.
2. Pulses of i_btn[0] lasting 1, 2 and 3 cycles -> no o_press, and o_state stays 00. A 4-cycle-stable pulse -> o_press.
3. Hold ch0 with i_repeat_en[0]=1 -> o_hold exactly 10 cycles after o_press and state 10, then o_repeat every 5 cycles. Release -> o_release after edge 7 of the release, then state 00.
4. Same hold with i_repeat_en[0]=0 -> o_hold but no o_repeat. Enable mid-HOLD -> repeat at the next 5-cycle boundary.
5. Release timed so d falls on the cycle hc==9 -> o_release only, no o_hold, state 00.
6. Assert i_rst_n=0 during HOLD -> outputs 0 immediately (asynchronous), no o_release. Deassert with the button still pressed -> o_press after 7 edges.

Source files
------------

// File: rtl/btn_event_detector.sv
// btn_event_detector: multi-channel button front end.
// Each channel synchronises its raw pad input, debounces it, and runs an
// IDLE/PRESS/HOLD state machine. The machine emits one-cycle pulses for
// press, hold, auto-repeat and release. Channels share nothing but the
// clock and reset.
module btn_event_detector #(
  parameter int NUM_CH        = 4,
  parameter int DEB_CYCLES    = 16,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_CH-1:0]   i_btn,
  input  logic [NUM_CH-1:0]   i_repeat_en,
  output logic [NUM_CH-1:0]   o_press,
  output logic [NUM_CH-1:0]   o_hold,
  output logic [NUM_CH-1:0]   o_repeat,
  output logic [NUM_CH-1:0]   o_release,
  output logic [2*NUM_CH-1:0] o_state
);

  // Same encoding as the protocol-wide state_e (IDLE=00, PRESS=01, HOLD=10).
  // The value 11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRESS = 2'b01,
    HOLD  = 2'b10
  } state_e;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          lvl;
    logic          deb;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nxt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;
    state_e        state;
    state_e        state_nxt;
    logic          press_q;
    logic          hold_q;
    logic          rep_q;
    logic          rel_q;
    logic          press_nxt;
    logic          hold_nxt;
    logic          rep_nxt;
    logic          rel_nxt;

    // Two-flop synchroniser that brings the asynchronous pad into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= i_btn[n];
        sync2 <= sync1;
      end
    end

    // Normalise polarity so that 1 always means pressed from here on.
    assign lvl = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    // Debouncer: accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        deb  <= 1'b0;
        dcnt <= '0;
      end else if (lvl != deb) begin
        if (dcnt == DEB_LAST) begin
          deb  <= lvl;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end else begin
        dcnt <= '0;
      end
    end

    // State, counters and pulse registers. A pulse lines up with the first
    // cycle of the new state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state   <= IDLE;
        hcnt    <= '0;
        rcnt    <= '0;
        press_q <= 1'b0;
        hold_q  <= 1'b0;
        rep_q   <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        hcnt    <= hcnt_nxt;
        rcnt    <= rcnt_nxt;
        press_q <= press_nxt;
        hold_q  <= hold_nxt;
        rep_q   <= rep_nxt;
        rel_q   <= rel_nxt;
      end
    end

    // Next-state logic. A release takes priority over a hold threshold or a
    // repeat tick in the same cycle.
    always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      rcnt_nxt  = rcnt;
      press_nxt = 1'b0;
      hold_nxt  = 1'b0;
      rep_nxt   = 1'b0;
      rel_nxt   = 1'b0;
      case (state)
        IDLE: begin
          if (deb) begin
            state_nxt = PRESS;
            press_nxt = 1'b1;
            hcnt_nxt  = '0;
          end
        end
        PRESS: begin
          if (!deb) begin
            state_nxt = IDLE;
            rel_nxt   = 1'b1;
          end else if (hcnt == HOLD_LAST) begin
            state_nxt = HOLD;
            hold_nxt  = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            hcnt_nxt = hcnt + 1'b1;
          end
        end
        HOLD: begin
          if (!deb) begin
            state_nxt = IDLE;
            rel_nxt   = 1'b1;
          end else if (rcnt == REP_LAST) begin
            rcnt_nxt = '0;
            rep_nxt  = i_repeat_en[n];
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    assign o_press[n]       = press_q;
    assign o_hold[n]        = hold_q;
    assign o_repeat[n]      = rep_q;
    assign o_release[n]     = rel_q;
    assign o_state[2*n +: 2] = state;
  end

endmodule
